// File: rtl/sprite_compositor_pkg.sv
// Shared constants, object attribute record and the procedural sprite image
// used by the fruit sprite compositor.
package fruit_pkg;

   localparam int NUM_OBJ    = 4;
   localparam int SPR_SIZE   = 32;
   localparam int PIX_LAT    = 2;
   localparam int COMMIT_ROW = 480;

   localparam int ROW_W  = 9;
   localparam int COL_W  = 10;
   localparam int TYPE_W = 3;
   localparam int IDX_W  = 2;
   localparam int PIX_W  = 12;
   localparam int SPR_AW = 5;
   localparam int ROM_AW = TYPE_W + 2 * SPR_AW;

   typedef struct packed {
      logic              en;
      logic [COL_W-1:0]  x;
      logic [ROW_W-1:0]  y;
      logic [TYPE_W-1:0] kind;
   } obj_attr_t;

   // Sprite image content for address {type, dy, dx}. Texels whose low three
   // dx bits equal the image number are transparent; the rest encode their
   // own coordinates so every opaque texel is distinguishable.
   function automatic logic [PIX_W-1:0] sprite_texel(input logic [ROM_AW-1:0] addr,
                                                     input logic [PIX_W-1:0]  key);
      logic [TYPE_W-1:0] t;
      logic [SPR_AW-1:0] dy;
      logic [SPR_AW-1:0] dx;
      t  = addr[ROM_AW-1 -: TYPE_W];
      dy = addr[2*SPR_AW-1 -: SPR_AW];
      dx = addr[SPR_AW-1:0];
      if (dx[2:0] == t)
         return key;
      return {t ^ {dx[4], 2'b00}, dy, dx[3:0]};
   endfunction

endpackage

// File: rtl/sprite_compositor_rom.sv
// 8192 x 12 sprite image store with a registered read port. The image is
// produced by sprite_texel so every instance holds identical content.
module sprite_rom
   import fruit_pkg::*;
#(
   parameter logic [PIX_W-1:0] KEY_COLOR = 12'hF0F
) (
   input  logic              clk,
   input  logic [ROM_AW-1:0] i_addr,
   output logic [PIX_W-1:0]  o_data
);

   logic [PIX_W-1:0] r_data_p1;

   // Synchronous read: data for the address presented this cycle appears next cycle.
   always_ff @(posedge clk) begin
      r_data_p1 <= sprite_texel(i_addr, KEY_COLOR);
   end

   assign o_data = r_data_p1;

endmodule

// File: rtl/sprite_compositor.sv
// Composites up to NUM_OBJ 32x32 sprites over a solid background for the VGA
// stage. Attributes are written into a shadow bank and copied to the active
// bank once per frame in vertical blank, so a frame never tears. The pixel
// path is a 2-stage pipeline computing two columns ahead of the live scan.
module sprite_compositor
   import fruit_pkg::*;
#(
   parameter int               NUM_OBJ   = fruit_pkg::NUM_OBJ,
   parameter logic [PIX_W-1:0] BG_COLOR  = 12'h420,
   parameter logic [PIX_W-1:0] KEY_COLOR = 12'hF0F
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ROW_W-1:0]  row,
   input  logic [COL_W-1:0]  col,
   input  logic              obj_we,
   input  logic [IDX_W-1:0]  obj_idx,
   input  logic              obj_en,
   input  logic [COL_W-1:0]  obj_x,
   input  logic [ROW_W-1:0]  obj_y,
   input  logic [TYPE_W-1:0] obj_type,
   output logic [PIX_W-1:0]  pix,
   output logic              frame_tick
);

   obj_attr_t         r_shadow [NUM_OBJ];
   obj_attr_t         r_active [NUM_OBJ];
   obj_attr_t         w_wr_attr;
   logic              w_commit;
   logic [COL_W-1:0]  w_pc_p0;
   logic [NUM_OBJ-1:0] w_hit_p0;
   logic [NUM_OBJ-1:0] r_hit_p1;
   logic [ROM_AW-1:0] w_addr_p0 [NUM_OBJ];
   logic [PIX_W-1:0]  w_texel_p1 [NUM_OBJ];
   logic [PIX_W-1:0]  w_sel_p1;
   logic [PIX_W-1:0]  r_pix_p2;
   logic              r_frame_tick;

   assign w_wr_attr = '{en: obj_en, x: obj_x, y: obj_y, kind: obj_type};

   // Commit happens at the first pixel of the first vertical-blank line.
   assign w_commit = (row == ROW_W'(COMMIT_ROW)) && (col == '0);

   // Look-ahead column; wraps mod 1024 so columns 0 and 1 come out right.
   assign w_pc_p0 = col + COL_W'(PIX_LAT);

   // Shadow bank: game-logic writes land here and are always accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OBJ; i++)
            r_shadow[i] <= '0;
      end else if (obj_we) begin
         for (int i = 0; i < NUM_OBJ; i++)
            if (obj_idx == IDX_W'(i))
               r_shadow[i] <= w_wr_attr;
      end
   end

   // Active bank: copies the pre-write shadow on the commit cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OBJ; i++)
            r_active[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_OBJ; i++)
            r_active[i] <= r_shadow[i];
      end
   end

   // ---- stage 0 -> 1: per-slot offsets, hit test and ROM address ----
   for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_slot
      logic [COL_W-1:0] w_dx_p0;
      logic [ROW_W-1:0] w_dy_p0;

      // Modular differences make sprites near x=1023 / y=511 wrap onto the left/top edge.
      assign w_dx_p0 = w_pc_p0 - r_active[gi].x;
      assign w_dy_p0 = row - r_active[gi].y;

      assign w_hit_p0[gi] = r_active[gi].en
                            && (w_dx_p0 < COL_W'(SPR_SIZE))
                            && (w_dy_p0 < ROW_W'(SPR_SIZE));

      assign w_addr_p0[gi] = {r_active[gi].kind, w_dy_p0[SPR_AW-1:0], w_dx_p0[SPR_AW-1:0]};

      sprite_rom #(
         .KEY_COLOR (KEY_COLOR)
      ) u_rom (
         .clk    (clk),
         .i_addr (w_addr_p0[gi]),
         .o_data (w_texel_p1[gi])
      );
   end

   // Hit flags registered alongside the ROM read so both arrive in stage 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_hit_p1 <= '0;
      else
         r_hit_p1 <= w_hit_p0;
   end

   // ---- stage 1 -> 2: priority select and output register ----
   // Lowest-index opaque hit wins; otherwise background.
   always_comb begin
      w_sel_p1 = BG_COLOR;
      for (int i = NUM_OBJ - 1; i >= 0; i--)
         if (r_hit_p1[i] && (w_texel_p1[i] != KEY_COLOR))
            w_sel_p1 = w_texel_p1[i];
   end

   // Output pixel and one-cycle commit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_p2     <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         r_pix_p2     <= w_sel_p1;
         r_frame_tick <= w_commit;
      end
   end

   assign pix        = r_pix_p2;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table of expected pixels per phase plus
// model-driven sweeps, compared through a latency-aligned scoreboard queue.
module tb_sprite_compositor;
   import fruit_pkg::*;

   localparam logic [11:0] BG  = 12'h420;
   localparam logic [11:0] KEY = 12'hF0F;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [8:0]  row = '0;
   logic [9:0]  col = '0;
   logic        obj_we = 1'b0;
   logic [1:0]  obj_idx = '0;
   logic        obj_en = 1'b0;
   logic [9:0]  obj_x = '0;
   logic [8:0]  obj_y = '0;
   logic [2:0]  obj_type = '0;
   logic [11:0] pix;
   logic        frame_tick;

   always #5 clk = ~clk;

   sprite_compositor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .row        (row),
      .col        (col),
      .obj_we     (obj_we),
      .obj_idx    (obj_idx),
      .obj_en     (obj_en),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .obj_type   (obj_type),
      .pix        (pix),
      .frame_tick (frame_tick)
   );

   typedef struct { bit chk; logic [11:0] exp; string nm; } sb_t;
   typedef struct { bit en; int x; int y; int t; } mobj_t;
   typedef struct { int ph; int r; int pc; logic [11:0] exp; string nm; } vec_t;

   sb_t   sb_q[$];
   mobj_t m_sh[4];
   mobj_t m_ac[4];
   vec_t  tv[$];
   int    total = 0;
   int    bad = 0;

   function automatic logic [11:0] rom_model(int t, int dy, int dx);
      int top;
      if ((dx % 8) == t) return KEY;
      top = (dx >= 16) ? (t ^ 4) : t;
      return 12'(top * 512 + dy * 16 + (dx % 16));
   endfunction

   function automatic logic [11:0] model_pix(int r, int pc);
      int dx, dy;
      logic [11:0] v;
      for (int i = 0; i < 4; i++) begin
         dx = (pc - m_ac[i].x + 1024) % 1024;
         dy = (r - m_ac[i].y + 512) % 512;
         if (m_ac[i].en && dx < 32 && dy < 32) begin
            v = rom_model(m_ac[i].t, dy, dx);
            if (v != KEY) return v;
         end
      end
      return BG;
   endfunction

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock: drive scan address, update the attribute model, score the output.
   task automatic cyc(input int r, input int c, input bit chk, input logic [11:0] expv, input string nm);
      sb_t e;
      row = 9'(r);
      col = 10'(c);
      if (r == 480 && c == 0) m_ac = m_sh;
      if (obj_we) m_sh[obj_idx] = '{obj_en, int'(obj_x), int'(obj_y), int'(obj_type)};
      sb_q.push_back('{chk, expv, nm});
      @(posedge clk);
      @(negedge clk);
      obj_we = 1'b0;
      check("frame_tick", {11'b0, frame_tick}, {11'b0, (r == 480 && c == 0)});
      if (sb_q.size() >= PIX_LAT) begin
         e = sb_q.pop_front();
         if (e.chk) check(e.nm, pix, e.exp);
      end
   endtask

   task automatic wr(input int idx, input bit en, input int x, input int y, input int t);
      obj_we = 1'b1; obj_idx = 2'(idx); obj_en = en;
      obj_x = 10'(x); obj_y = 9'(y); obj_type = 3'(t);
      cyc(200, 500, 1'b0, '0, "wr");
   endtask

   task automatic commit();
      cyc(480, 0, 1'b0, '0, "commit");
   endtask

   task automatic pxm(input int r, input int pc, input string nm);
      cyc(r, (pc + 1022) % 1024, 1'b1, model_pix(r, pc), nm);
   endtask

   task automatic run_phase(input int ph);
      foreach (tv[i])
         if (tv[i].ph == ph)
            cyc(tv[i].r, (tv[i].pc + 1022) % 1024, 1'b1, tv[i].exp, tv[i].nm);
   endtask

   task automatic sweep(input int n, input string nm);
      for (int k = 0; k < n; k++)
         pxm($urandom_range(0, 479), $urandom_range(0, 1023), nm);
   endtask

   initial begin
      tv.push_back('{2, 50, 100, BG,      "pre_commit"});
      tv.push_back('{3, 50, 100, 12'h200, "spr_00"});
      tv.push_back('{3, 81, 131, 12'hBFF, "spr_3131"});
      tv.push_back('{3, 60, 110, 12'h2AA, "spr_1010"});
      tv.push_back('{3, 50, 101, BG,      "spr_keyed"});
      tv.push_back('{3, 50, 99,  BG,      "left_out"});
      tv.push_back('{3, 50, 132, BG,      "right_out"});
      tv.push_back('{3, 82, 100, BG,      "below_out"});
      tv.push_back('{4, 50, 100, 12'h200, "prio_slot0"});
      tv.push_back('{4, 50, 101, 12'h401, "key_fallthru"});
      tv.push_back('{4, 50, 300, 12'h800, "slot2"});
      tv.push_back('{4, 50, 304, BG,      "both_keyed"});
      tv.push_back('{5, 50, 100, 12'h200, "wcommit_old"});
      tv.push_back('{5, 50, 600, BG,      "wcommit_notyet"});
      tv.push_back('{6, 50, 600, 12'h200, "wcommit_moved"});
      tv.push_back('{6, 50, 100, 12'h400, "wcommit_under"});
      tv.push_back('{7, 0,  0,    12'h4C8, "wrap_col0"});
      tv.push_back('{7, 0,  1,    12'h4C9, "wrap_col1"});
      tv.push_back('{7, 19, 7,    12'h5FF, "wrap_corner"});
      tv.push_back('{7, 19, 1023, 12'h5F7, "wrap_c1023"});
      tv.push_back('{7, 0,  1000, 12'hCC0, "wrap_left"});
      tv.push_back('{7, 20, 0,    BG,      "wrap_below"});
      tv.push_back('{7, 0,  8,    BG,      "wrap_right"});
      tv.push_back('{8, 50, 100, BG, "rst_bg_a"});
      tv.push_back('{8, 0,  0,   BG, "rst_bg_b"});
      tv.push_back('{8, 50, 300, BG, "rst_bg_c"});

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_pix", pix, 12'h000);
      check("reset_tick", {11'b0, frame_tick}, 12'h000);
      rst_n = 1'b1;

      // Test 1: no writes, background everywhere, ticks on commit
      sweep(40, "bg_idle");
      commit();
      sweep(20, "bg_idle2");
      commit();

      // Test 2: single sprite gated by commit
      wr(0, 1'b1, 100, 50, 1);
      run_phase(2);
      commit();
      run_phase(3);

      // Test 3: priority and transparency
      wr(1, 1'b1, 100, 50, 2);
      wr(2, 1'b1, 300, 50, 4);
      wr(3, 1'b1, 300, 50, 4);
      commit();
      run_phase(4);
      sweep(30, "sweep_prio");

      // Test 4: write on the commit cycle lands one frame later
      obj_we = 1'b1; obj_idx = 2'd0; obj_en = 1'b1;
      obj_x = 10'd600; obj_y = 9'd50; obj_type = 3'd1;
      commit();
      run_phase(5);
      commit();
      run_phase(6);

      // Test 5: left/top edge wrap and look-ahead wrap
      wr(3, 1'b1, 1000, 500, 6);
      commit();
      run_phase(7);
      for (int c = 0; c < 10; c++) pxm(5, c, "wrap_scan");
      for (int c = 1016; c < 1024; c++) pxm(5, c, "wrap_scan_r");

      // Test 6: mid-frame reset
      pxm(50, 100, "pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("midrst_pix", pix, 12'h000);
      check("midrst_tick", {11'b0, frame_tick}, 12'h000);
      sb_q.delete();
      foreach (m_sh[i]) begin
         m_sh[i] = '{1'b0, 0, 0, 0};
         m_ac[i] = '{1'b0, 0, 0, 0};
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_phase(8);
      commit();
      run_phase(8);
      sweep(20, "rst_sweep");
      commit();
      run_phase(8);

      repeat (PIX_LAT) cyc(200, 0, 1'b0, '0, "flush");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
